// File: rtl/display_scan7seg_pkg.sv
// display_pkg: shared constants for the multi-digit seven-segment scanner.
//   SEG_W      : width of a segment pattern (a..g)
//   SEG_OFF    : all segments dark (before any output inversion)
//   SEG_A..G   : bit positions of each segment within a pattern
//   SEG_HEX    : hex digit -> segment pattern table, 1 = lit
//   idx_width  : width of a digit index for a given digit count (min 1)
package display_pkg;

  localparam int SEG_W = 7;

  localparam logic [SEG_W-1:0] SEG_OFF = 7'h00;

  localparam int SEG_A = 0;
  localparam int SEG_B = 1;
  localparam int SEG_C = 2;
  localparam int SEG_D = 3;
  localparam int SEG_E = 4;
  localparam int SEG_F = 5;
  localparam int SEG_G = 6;

  localparam logic [SEG_W-1:0] SEG_HEX [16] = '{
    7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07,
    7'h7F, 7'h6F, 7'h77, 7'h7C, 7'h39, 7'h5E, 7'h79, 7'h71
  };

  function automatic int idx_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/display_scan7seg_if.sv
// display_scan7seg_if: data/control bundle between the game logic, the
// scanner and the display pins.
//   digits_in : packed hex digits, digit i at [4i+3:4i], digit 0 rightmost
//   update    : rising edge requests a capture of digits_in
//   blank_lz  : level, enables leading-zero blanking
//   seg_out   : registered segment pattern (bit0 = a .. bit6 = g)
//   digit_sel : registered one-hot digit enable
// master = producer of digits / consumer of pins, slave = the scanner.
interface display_scan7seg_if
  import display_pkg::*;
#(
  parameter int NUM_DIGITS = 4
);

  logic [4*NUM_DIGITS-1:0] digits_in;
  logic                    update;
  logic                    blank_lz;
  logic [SEG_W-1:0]        seg_out;
  logic [NUM_DIGITS-1:0]   digit_sel;

  modport master (
    output digits_in,
    output update,
    output blank_lz,
    input  seg_out,
    input  digit_sel
  );

  modport slave (
    input  digits_in,
    input  update,
    input  blank_lz,
    output seg_out,
    output digit_sel
  );

endinterface

// File: rtl/display_scan7seg_decode.sv
// seg7_hex_decode: combinational hex digit to seven-segment pattern.
//   hex : 4-bit digit value 0..F
//   seg : pattern, bit0 = a .. bit6 = g, 1 = lit
module seg7_hex_decode
  import display_pkg::*;
(
  input  logic [3:0]       hex,
  output logic [SEG_W-1:0] seg
);

  assign seg = SEG_HEX[hex];

endmodule

// File: rtl/display_scan7seg.sv
// display_scan7seg: captures a packed vector of hex digits on a rising edge
// of update and time-multiplexes them onto one shared segment bus with a
// one-hot digit select, with optional leading-zero blanking and a few dark
// clocks at the start of each slot to suppress ghosting.
//   clock   : sole clock, rising edge
//   reset_n : asynchronous active-low reset, drives the outputs dark
//   bus     : display_scan7seg_if slave (digits_in, update, blank_lz in;
//             seg_out, digit_sel out)
// Parameters: NUM_DIGITS (1..8), SCAN_DIV (clocks per slot, >=2),
// BLANK_CYCLES (dark clocks per slot, < SCAN_DIV), INVERT_OUTPUT (1 for
// active-low pins; inverts both seg_out and digit_sel).
module display_scan7seg
  import display_pkg::*;
#(
  parameter int NUM_DIGITS    = 4,
  parameter int SCAN_DIV      = 50000,
  parameter int BLANK_CYCLES  = 2,
  parameter bit INVERT_OUTPUT = 1'b0
)
(
  input  logic              clock,
  input  logic              reset_n,
  display_scan7seg_if.slave bus
);

  localparam int PRE_W = $clog2(SCAN_DIV);
  localparam int IDX_W = idx_width(NUM_DIGITS);
  // Digit slots rounded up to a power of two so idx can never index
  // past the end of the padded vectors below.
  localparam int NSLOT = 1 << IDX_W;

  localparam logic [PRE_W-1:0]      PRE_LAST = PRE_W'(SCAN_DIV - 1);
  localparam logic [IDX_W-1:0]      IDX_LAST = IDX_W'(NUM_DIGITS - 1);
  localparam logic [SEG_W-1:0]      SEG_INV  = INVERT_OUTPUT ? 7'h7F : 7'h00;
  localparam logic [NUM_DIGITS-1:0] SEL_INV  = INVERT_OUTPUT ? '1 : '0;

  logic                    update_q;
  logic                    capture;
  logic [4*NUM_DIGITS-1:0] shadow;
  logic [PRE_W-1:0]        pre;
  logic [IDX_W-1:0]        idx;

  logic [4*NSLOT-1:0]      shadow_pad;
  logic [NSLOT-1:0]        zero_from;
  logic [3:0]              cur_digit;
  logic [SEG_W-1:0]        dec_seg;
  logic                    in_blank_window;
  logic                    digit_blanked;
  logic [SEG_W-1:0]        seg_next;
  logic [NUM_DIGITS-1:0]   sel_next;

  logic [SEG_W-1:0]        seg_p1;
  logic [NUM_DIGITS-1:0]   sel_p1;

  // ---- stage p0: edge detect, shadow capture, slot counters ----
  assign capture = bus.update & ~update_q;

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      update_q <= 1'b0;
      shadow   <= '0;
    end else begin
      update_q <= bus.update;
      if (capture) begin
        shadow <= bus.digits_in;
      end
    end
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      pre <= '0;
      idx <= '0;
    end else if (pre == PRE_LAST) begin
      pre <= '0;
      idx <= (idx == IDX_LAST) ? '0 : idx + 1'b1;
    end else begin
      pre <= pre + 1'b1;
    end
  end

  always_comb begin
    shadow_pad = '0;
    shadow_pad[4*NUM_DIGITS-1:0] = shadow;
  end

  // zero_from[i] is set when digit i and every digit above it are zero.
  // The padding slots are zero, so they never break the chain.
  always_comb begin
    logic acc;
    acc       = 1'b1;
    zero_from = '1;
    for (int i = NSLOT - 1; i >= 0; i--) begin
      acc          = acc & (shadow_pad[4*i +: 4] == 4'h0);
      zero_from[i] = acc;
    end
  end

  assign cur_digit = shadow_pad[{idx, 2'b00} +: 4];

  seg7_hex_decode u_decode (
    .hex (cur_digit),
    .seg (dec_seg)
  );

  assign in_blank_window = 32'(pre) < BLANK_CYCLES;
  // Digit 0 is exempt so an all-zero value still shows a single "0".
  assign digit_blanked   = bus.blank_lz && (idx != '0) && zero_from[idx];

  assign seg_next = (in_blank_window || digit_blanked) ? SEG_OFF : dec_seg;
  assign sel_next = NUM_DIGITS'(1) << idx;

  // ---- stage p1: registered pin drivers ----
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      seg_p1 <= SEG_OFF ^ SEG_INV;
      sel_p1 <= SEL_INV;
    end else begin
      seg_p1 <= seg_next ^ SEG_INV;
      sel_p1 <= sel_next ^ SEL_INV;
    end
  end

  assign bus.seg_out   = seg_p1;
  assign bus.digit_sel = sel_p1;

endmodule

// File: tb/tb_display_scan7seg.sv
module tb_display_scan7seg;

  localparam int SCAN = 4;
  localparam int BLK  = 1;

  logic clock = 1'b0;
  logic rst_n = 1'b0;

  always #5 clock = ~clock;

  display_scan7seg_if #(.NUM_DIGITS(4)) bus_a ();
  display_scan7seg_if #(.NUM_DIGITS(1)) bus_b ();

  display_scan7seg #(
    .NUM_DIGITS    (4),
    .SCAN_DIV      (SCAN),
    .BLANK_CYCLES  (BLK),
    .INVERT_OUTPUT (1'b0)
  ) dut_a (
    .clock   (clock),
    .reset_n (rst_n),
    .bus     (bus_a)
  );

  display_scan7seg #(
    .NUM_DIGITS    (1),
    .SCAN_DIV      (SCAN),
    .BLANK_CYCLES  (BLK),
    .INVERT_OUTPUT (1'b1)
  ) dut_b (
    .clock   (clock),
    .reset_n (rst_n),
    .bus     (bus_b)
  );

  logic [6:0] hex_tab [16] = '{
    7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07,
    7'h7F, 7'h6F, 7'h77, 7'h7C, 7'h39, 7'h5E, 7'h79, 7'h71
  };

  int n_chk  = 0;
  int n_fail = 0;

  // Reference state: cycles since reset release, value currently held for
  // display, and the previous sampled update level.
  int cyc_a = 0, sh_a = 0, upv_a = 0;
  int cyc_b = 0, sh_b = 0, upv_b = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  // Display of a 4-digit unit at output cycle c: slot c/SCAN, position c%SCAN.
  function automatic int exp_a_seg();
    int pre, idx, dig, upper;
    bit blanked;
    pre     = cyc_a % SCAN;
    idx     = (cyc_a / SCAN) % 4;
    upper   = sh_a >> (4 * idx);
    dig     = upper & 15;
    blanked = (bus_a.blank_lz == 1'b1) && (idx != 0) && (upper == 0);
    if (pre < BLK || blanked) return 0;
    return int'(hex_tab[dig]);
  endfunction

  function automatic int exp_a_sel();
    return 1 << ((cyc_a / SCAN) % 4);
  endfunction

  function automatic int exp_b_seg();
    int s;
    s = ((cyc_b % SCAN) < BLK) ? 0 : int'(hex_tab[sh_b & 15]);
    return s ^ 32'h7F;
  endfunction

  task automatic step();
    @(posedge clock);
    #1;
    if (!rst_n) begin
      chk("rst_a_seg", 32'(bus_a.seg_out),   32'h00);
      chk("rst_a_sel", 32'(bus_a.digit_sel), 32'h0);
      chk("rst_b_seg", 32'(bus_b.seg_out),   32'h7F);
      chk("rst_b_sel", 32'(bus_b.digit_sel), 32'h1);
    end else begin
      chk("a_seg", 32'(bus_a.seg_out),   32'(exp_a_seg()));
      chk("a_sel", 32'(bus_a.digit_sel), 32'(exp_a_sel()));
      chk("b_seg", 32'(bus_b.seg_out),   32'(exp_b_seg()));
      chk("b_sel", 32'(bus_b.digit_sel), 32'h0);
      if (bus_a.update && upv_a == 0) sh_a = int'(bus_a.digits_in);
      upv_a = int'(bus_a.update);
      cyc_a++;
      if (bus_b.update && upv_b == 0) sh_b = int'(bus_b.digits_in);
      upv_b = int'(bus_b.update);
      cyc_b++;
    end
  endtask

  task automatic run(input int n);
    for (int i = 0; i < n; i++) step();
  endtask

  // Asserts reset between edges, checks the outputs went dark without a
  // clock, then releases and restarts the reference from scratch.
  task automatic do_reset(input int n);
    rst_n = 1'b0;
    #1;
    chk("async_a_seg", 32'(bus_a.seg_out),   32'h00);
    chk("async_a_sel", 32'(bus_a.digit_sel), 32'h0);
    chk("async_b_seg", 32'(bus_b.seg_out),   32'h7F);
    chk("async_b_sel", 32'(bus_b.digit_sel), 32'h1);
    run(n);
    rst_n = 1'b1;
    cyc_a = 0; sh_a = 0; upv_a = 0;
    cyc_b = 0; sh_b = 0; upv_b = 0;
  endtask

  task automatic pulse(input logic [15:0] va, input logic [3:0] vb);
    bus_a.digits_in = va;
    bus_b.digits_in = vb;
    bus_a.update = 1'b1;
    bus_b.update = 1'b1;
    step();
    bus_a.update = 1'b0;
    bus_b.update = 1'b0;
  endtask

  initial begin
    bus_a.digits_in = '0; bus_a.update = 1'b0; bus_a.blank_lz = 1'b0;
    bus_b.digits_in = '0; bus_b.update = 1'b0; bus_b.blank_lz = 1'b0;

    // Reset state, then a plain scan of the all-zero shadow.
    run(3);
    rst_n = 1'b1;
    run(20);

    // Single capture.
    pulse(16'h1234, 4'h8);
    run(18);

    // Held update: only the first edge captures.
    bus_a.digits_in = 16'h1234;
    bus_a.update = 1'b1;
    for (int i = 1; i <= 10; i++) begin
      if (i == 5) bus_a.digits_in = 16'h5678;
      step();
    end
    bus_a.update = 1'b0;
    run(16);
    pulse(16'h5678, 4'h3);
    run(16);

    // Leading-zero blanking.
    bus_a.blank_lz = 1'b1;
    pulse(16'h0070, 4'h0);
    run(16);
    pulse(16'h0000, 4'h0);
    run(16);
    bus_a.blank_lz = 1'b0;
    run(16);

    // Randomized traffic.
    for (int i = 0; i < 300; i++) begin
      bus_a.digits_in = 16'($urandom) >> (4 * $urandom_range(0, 4));
      bus_a.update    = ($urandom_range(0, 3) == 0);
      if ($urandom_range(0, 15) == 0) bus_a.blank_lz = ~bus_a.blank_lz;
      bus_b.digits_in = 4'($urandom);
      bus_b.update    = ($urandom_range(0, 3) == 0);
      bus_b.blank_lz  = 1'($urandom);
      step();
    end
    bus_a.update = 1'b0;
    bus_b.update = 1'b0;

    // Reset mid-scan: realign, walk to idx=2 pre=2, then reset.
    do_reset(2);
    pulse(16'hBEEF, 4'hC);
    run(9);
    do_reset(3);
    run(20);

    // Update already high at the first edge after reset counts as an edge.
    bus_a.digits_in = 16'hA5C3;
    bus_a.update = 1'b1;
    do_reset(2);
    run(20);
    bus_a.update = 1'b0;
    run(4);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/display_scan7seg.md
# display_scan7seg

Parametrised multi-digit successor to the single-digit seven-segment decoder. It captures a packed vector of 4-bit hex digits on a rising edge of `update` and holds it in a shadow register. It time-multiplexes the digits onto one shared segment bus with a one-hot digit-select, and adds optional leading-zero blanking and anti-ghosting blank cycles. It sits between the score/game logic and the board's common-anode/cathode display pins.

## Interface
- `NUM_DIGITS`, 4: digit count, legal 1..8.
- `SCAN_DIV`, 50000: clocks per digit slot, legal ≥2.
- `BLANK_CYCLES`, 2: clocks at the start of each slot with segments forced off, legal 0..SCAN_DIV-1.
- `INVERT_OUTPUT`, 0: 1 inverts both `seg_out` and `digit_sel`, for active-low displays.
- `clock` in 1: sole clock, rising edge.
- `reset_n` in 1: asynchronous, active-low reset.
- `digits_in` in 4*NUM_DIGITS: digit i is `[4i+3:4i]`; digit 0 is the rightmost/least significant.
- `update` in 1: synchronous to `clock`; only a rising edge triggers capture.
- `blank_lz` in 1: level; 1 enables leading-zero blanking.
- `seg_out` out 7: bit0=a … bit6=g; 1 = lit, before inversion.
- `digit_sel` out NUM_DIGITS: one-hot; 1 = enabled, before inversion.

## Operation
- **Edge detect:** `update_q` is a register of `update`.
  - Capture occurs when `update & ~update_q`.
  - `update_q` resets to 0, so `update` already high at the first post-reset edge counts as an edge.
  - Holding `update` high gives exactly one capture.
- **Capture:** `shadow <= digits_in`.
- **Prescaler:** `pre` counts 0..SCAN_DIV-1 and wraps to 0. On wrap, `idx` advances modulo NUM_DIGITS (NUM_DIGITS-1 → 0).
  - Width of `pre` is `$clog2(SCAN_DIV)`.
  - Width of `idx` is `max(1,$clog2(NUM_DIGITS))`.
  - With NUM_DIGITS=1, `idx` stays 0.
- **Leading-zero blanking:** digit i ≥1 is blanked when `blank_lz`=1 and digits i..NUM_DIGITS-1 of `shadow` are all zero. Digit 0 is never blanked, so all-zero input shows a single "0".
- **Decode (hex):** 0:3F 1:06 2:5B 3:4F 4:66 5:6D 6:7D 7:07 8:7F 9:6F A:77 b:7C C:39 d:5E E:79 F:71.
- **Segment value:**
  - `seg_next` = 7'h00 if `pre < BLANK_CYCLES` or the digit is blanked.
  - Otherwise `seg_next` = `decode(shadow[idx])`.
- **Select value:** `sel_next = 1 << idx`, always exactly one bit; it is not affected by blanking.
- **Outputs:** `seg_out` and `digit_sel` are registered; both XOR all-ones when INVERT_OUTPUT=1.
- **Reset values:**
  - `shadow`=0, `pre`=0, `idx`=0, `update_q`=0.
  - `seg_out`=7'h00 and `digit_sel`=0 (INVERT_OUTPUT=0), or 7'h7F and all-ones (INVERT_OUTPUT=1), i.e. all dark.

## Timing
- All state is updated on the rising edge of `clock`.
- Output registers sample the pre-edge `pre`, `idx` and `shadow`, giving one cycle of latency:
  - a capture at edge E appears on `seg_out` at edge E+1, within the current slot;
  - an `idx` change at edge T appears on `digit_sel` at edge T+1.
- First full display pass after reset: digit 0 is shown from edge 1. Each slot lasts exactly SCAN_DIV cycles on the outputs.
- Capture coinciding with slot wrap: the new slot shows the new `shadow` one cycle later, with no mixed frame.
- `blank_lz` changes take effect on the next output edge.
- `reset_n` asserted mid-slot forces outputs dark immediately, without waiting for a clock. After deassertion, scanning restarts at digit 0 with `pre`=0.

## Structure
- Package `display_pkg` holds:
  - `SEG_OFF` (7'h00);
  - the 16-entry `SEG_HEX` pattern constant;
  - the segment bit-index localparams a..g.
- Sub-module `seg7_hex_decode`: combinational, 4-bit in → 7-bit out, using `display_pkg`.
- The top level contains the edge detect, shadow register, prescaler/index counters, leading-zero logic and output registers.

## Test plan
All scenarios use NUM_DIGITS=4, SCAN_DIV=4, BLANK_CYCLES=1 unless noted.
- **Reset with INVERT_OUTPUT=0:** hold `reset_n` low → `seg_out`=00, `digit_sel`=0000. Release → `digit_sel` cycles 0001, 0010, 0100, 1000, 0001, four clocks each. Every slot's first cycle has `seg_out`=00, and the other three cycles show 3F.
- **Single capture:** `digits_in`=16'h1234, one-cycle `update` pulse → non-blank slot values: digit0=66, digit1=4F, digit2=5B, digit3=06.
- **Held update:** hold `update` high for 10 cycles; at cycle 5 change `digits_in` from 16'h1234 to 16'h5678 → display stays 1234. A new pulse after `update` returns low shows digit0=7F, digit3=6D.
- **Leading-zero blanking:** `blank_lz`=1.
  - 16'h0070 → digit3 and digit2 show 00, digit1=07, digit0=3F.
  - 16'h0000 → only digit0 shows 3F.
  - `blank_lz`=0 with 16'h0000 → all four digits show 3F.
- **Inverted variant:** INVERT_OUTPUT=1, NUM_DIGITS=1.
  - Reset → `seg_out`=7F, `digit_sel`=1.
  - Capture 4'h8 → `digit_sel` constant 0; `seg_out`=7F in the blank cycle and 00 otherwise.
- **Reset mid-scan:** assert `reset_n` asynchronously while `idx`=2, `pre`=2 → outputs dark before the next clock edge. After release, `digit_sel`=0001 at edge 1 and `shadow` reads 0.
